// File: rtl/machine_pkg.sv
// ---------------------------------------------------------------------------
// machine_pkg
// Shared definitions for the machine: RAM geometry constants and the
// encoding of the RAM owner, used both as the arbiter FSM state and as the
// read-tag value that routes returning data.
// ---------------------------------------------------------------------------
package machine_pkg;

   localparam int unsigned RAM_ADDR_W  = 8;
   localparam int unsigned RAM_DATA_W  = 8;
   // Wide enough for the largest legal burst limit (15).
   localparam int unsigned BURST_CNT_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } ram_owner_e;

endpackage

// File: rtl/arb_burst_cnt.sv
// ---------------------------------------------------------------------------
// arb_burst_cnt
// Saturating count of consecutive grants to the current RAM owner.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : return to 0 (no access this cycle)
//   load1      : restart at 1 (ownership changed)
//   inc        : one more grant to the same owner, saturating at MAX
//   limit      : count has reached MAX
// Priority when several controls are high: clear, then load1, then inc.
// ---------------------------------------------------------------------------
module arb_burst_cnt #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned MAX   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic load1,
   input  logic inc,
   output logic limit
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (load1) begin
         cnt_q <= CNT_W'(1);
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Saturating at MAX (not at the counter width) keeps limit asserted for a
   // long solo burst, so a newly arriving master is served immediately.
   assign limit = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single-port RAM between the CPU and the debug/loader port.
// One request is granted per cycle (combinational *_gnt), the RAM command is
// registered one cycle later, and read data returns to the issuing master two
// cycles after the grant, routed by a 2-entry tag shift register.
//   clk, reset                   : clock, asynchronous active-low reset
//   cpu_* / dbg_* req,we,addr,wdata : master commands, held until granted
//   cpu_gnt / dbg_gnt            : request accepted this cycle
//   cpu_rvalid/rdata, dbg_rvalid/rdata : read return (rdata 0 when not valid)
//   ram_addr, ram_wdata, ram_we  : registered RAM command
//   ram_rdata                    : RAM data, one cycle after ram_addr
//   owner                        : owner of the last issued access
// Build option: RAM_ARB_RR_EN selects round-robin on contention instead of
// CPU priority with the MAX_BURST override.
// ---------------------------------------------------------------------------
module ram_arbiter
   import machine_pkg::*;
#(
   parameter int unsigned ADDR_W    = RAM_ADDR_W,
   parameter int unsigned DATA_W    = RAM_DATA_W,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              dbg_req,
   input  logic              cpu_we,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              cpu_gnt,
   output logic              dbg_gnt,
   output logic              cpu_rvalid,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [1:0]        owner
);

   // OWN_NONE doubles as the IDLE state.
   ram_owner_e state_q, state_d;
   ram_owner_e tag0_q, tag1_q;
   logic       cnt_clear, cnt_load1, cnt_inc, cnt_limit;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   arb_burst_cnt #(
      .CNT_W (BURST_CNT_W),
      .MAX   (MAX_BURST)
   ) u_burst_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .limit (cnt_limit)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the block can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = OWN_NONE;
      cpu_gnt   = 1'b0;
      dbg_gnt   = 1'b0;
      cnt_clear = 1'b0;
      cnt_load1 = 1'b0;
      cnt_inc   = 1'b0;

      if (cpu_req && dbg_req) begin
`ifdef RAM_ARB_RR_EN
         state_d = (state_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
`else
         state_d = (state_q == OWN_CPU && cnt_limit) ? OWN_DBG : OWN_CPU;
`endif
      end else if (cpu_req) begin
         state_d = OWN_CPU;
      end else if (dbg_req) begin
         state_d = OWN_DBG;
      end

      // Grants are combinational, so they must be suppressed while the
      // asynchronous reset is held.
      if (!reset) begin
         state_d = OWN_NONE;
      end

      cpu_gnt = (state_d == OWN_CPU);
      dbg_gnt = (state_d == OWN_DBG);

      if (state_d == OWN_NONE) begin
         cnt_clear = 1'b1;
      end else if (state_d == state_q) begin
         cnt_inc   = 1'b1;
      end else begin
         cnt_load1 = 1'b1;
      end
   end

   assign sel_we    = (state_d == OWN_DBG) ? dbg_we    : cpu_we;
   assign sel_addr  = (state_d == OWN_DBG) ? dbg_addr  : cpu_addr;
   assign sel_wdata = (state_d == OWN_DBG) ? dbg_wdata : cpu_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= OWN_NONE;
      end else begin
         state_q <= state_d;
      end
   end

   // RAM command registers and read-tag pipeline. Tags are cleared by reset
   // so reads granted before reset never return data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
         tag0_q    <= OWN_NONE;
         tag1_q    <= OWN_NONE;
      end else begin
         ram_we <= (state_d != OWN_NONE) && sel_we;
         if (state_d != OWN_NONE) begin
            ram_addr <= sel_addr;
            if (sel_we) begin
               ram_wdata <= sel_wdata;
            end
         end
         tag0_q <= (state_d != OWN_NONE && !sel_we) ? state_d : OWN_NONE;
         tag1_q <= tag0_q;
      end
   end

   assign cpu_rvalid = (tag1_q == OWN_CPU);
   assign dbg_rvalid = (tag1_q == OWN_DBG);
   assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
   assign dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
   assign owner      = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Self-checking bench for ram_arbiter with a synchronous RAM model whose
// initial content is addr ^ 8'h5A. Expected grant patterns follow the
// RAM_ARB_RR_EN build option.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_req, dbg_req, cpu_we, dbg_we;
   logic [7:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata;
   logic       cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
   logic [7:0] cpu_rdata, dbg_rdata;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;
   logic       ram_we;
   logic [1:0] owner;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .dbg_req    (dbg_req),
      .cpu_we     (cpu_we),
      .dbg_we     (dbg_we),
      .cpu_addr   (cpu_addr),
      .dbg_addr   (dbg_addr),
      .cpu_wdata  (cpu_wdata),
      .dbg_wdata  (dbg_wdata),
      .cpu_gnt    (cpu_gnt),
      .dbg_gnt    (dbg_gnt),
      .cpu_rvalid (cpu_rvalid),
      .dbg_rvalid (dbg_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_rdata  (dbg_rdata),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata),
      .owner      (owner)
   );

   // Synchronous read-first RAM, preloaded on the first clock edge.
   logic [7:0] mem [256];
   logic       loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
         loaded    <= 1'b1;
         ram_rdata <= 8'h00;
      end else begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       creq, cwe;
      logic [7:0] caddr, cwd;
      logic       dreq, dwe;
      logic [7:0] daddr, dwd;
      logic       cg, dg;
      logic       crv;
      logic [7:0] crd;
      logic       drv;
      logic [7:0] drd;
      logic [1:0] own;
      logic       we;
      logic [7:0] addr, wd;
   } vec_t;

   vec_t vecs [18];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_cpu [14];
      // One row per cycle. Registered outputs reflect the previous row's
      // grant; rvalid/rdata reflect the grant two rows earlier.
      //            creq cwe caddr   cwd    dreq dwe daddr   dwd    cg dg crv crd    drv drd    own   we addr   wd
      vecs[0]  = '{1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0, 8'h00, 8'h00};
      vecs[1]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 2'd1, 0, 8'h00, 8'h00};
      vecs[2]  = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h3C, 0, 1, 1, 8'h5A, 0, 8'h00, 2'd0, 0, 8'h00, 8'h00};
      vecs[3]  = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h3C, 0, 1, 0, 8'h00, 0, 8'h00, 2'd2, 1, 8'h10, 8'h3C};
      vecs[4]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 2'd2, 0, 8'h10, 8'h3C};
      vecs[5]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h3C, 2'd0, 0, 8'h10, 8'h3C};
      vecs[6]  = '{1, 0, 8'h01, 8'h3C, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0, 8'h10, 8'h3C};
      vecs[7]  = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h3C, 0, 1, 0, 8'h00, 0, 8'h00, 2'd1, 0, 8'h01, 8'h3C};
      vecs[8]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h5B, 0, 8'h00, 2'd2, 0, 8'h02, 8'h3C};
      vecs[9]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h58, 2'd0, 0, 8'h02, 8'h3C};
      vecs[10] = '{1, 1, 8'h20, 8'hC3, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0, 8'h02, 8'h3C};
      vecs[11] = '{1, 0, 8'h20, 8'hC3, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 2'd1, 1, 8'h20, 8'hC3};
      vecs[12] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 2'd1, 0, 8'h20, 8'hC3};
      vecs[13] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'hC3, 0, 8'h00, 2'd0, 0, 8'h20, 8'hC3};
      vecs[14] = '{1, 0, 8'h03, 8'hC3, 1, 0, 8'h04, 8'hC3, 1, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0, 8'h20, 8'hC3};
      vecs[15] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h04, 8'hC3, 0, 1, 0, 8'h00, 0, 8'h00, 2'd1, 0, 8'h03, 8'hC3};
      vecs[16] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h59, 0, 8'h00, 2'd2, 0, 8'h04, 8'hC3};
      vecs[17] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h5E, 2'd0, 0, 8'h04, 8'hC3};

      // Reset held with both masters requesting writes: everything stays 0.
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h77; cpu_wdata = 8'hEE;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h66; dbg_wdata = 8'hDD;
      repeat (2) @(posedge clk);
      #6;
      check("rst cpu_gnt",    32'(cpu_gnt),    0);
      check("rst dbg_gnt",    32'(dbg_gnt),    0);
      check("rst cpu_rvalid", 32'(cpu_rvalid), 0);
      check("rst dbg_rvalid", 32'(dbg_rvalid), 0);
      check("rst cpu_rdata",  32'(cpu_rdata),  0);
      check("rst dbg_rdata",  32'(dbg_rdata),  0);
      check("rst ram_addr",   32'(ram_addr),   0);
      check("rst ram_wdata",  32'(ram_wdata),  0);
      check("rst ram_we",     32'(ram_we),     0);
      check("rst owner",      32'(owner),      0);

      // Directed table; reset is released together with the first row.
      for (int i = 0; i < 18; i++) begin
         @(posedge clk);
         #1;
         reset     = 1'b1;
         cpu_req   = vecs[i].creq;  cpu_we = vecs[i].cwe;
         cpu_addr  = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
         dbg_req   = vecs[i].dreq;  dbg_we = vecs[i].dwe;
         dbg_addr  = vecs[i].daddr; dbg_wdata = vecs[i].dwd;
         #5;
         check($sformatf("row%0d cpu_gnt", i),    32'(cpu_gnt),    32'(vecs[i].cg));
         check($sformatf("row%0d dbg_gnt", i),    32'(dbg_gnt),    32'(vecs[i].dg));
         check($sformatf("row%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].crv));
         check($sformatf("row%0d cpu_rdata", i),  32'(cpu_rdata),  32'(vecs[i].crd));
         check($sformatf("row%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].drv));
         check($sformatf("row%0d dbg_rdata", i),  32'(dbg_rdata),  32'(vecs[i].drd));
         check($sformatf("row%0d owner", i),      32'(owner),      32'(vecs[i].own));
         check($sformatf("row%0d ram_we", i),     32'(ram_we),     32'(vecs[i].we));
         check($sformatf("row%0d ram_addr", i),   32'(ram_addr),   32'(vecs[i].addr));
         check($sformatf("row%0d ram_wdata", i),  32'(ram_wdata),  32'(vecs[i].wd));
      end

      // Contention: both masters read continuously from idle for 12 cycles.
      for (int k = 0; k < 14; k++) begin
`ifdef RAM_ARB_RR_EN
         exp_cpu[k] = (k % 2) == 0;
`else
         exp_cpu[k] = (k % 5) != 4;
`endif
      end
      for (int k = 0; k < 14; k++) begin
         @(posedge clk);
         #1;
         cpu_req = (k < 12); cpu_we = 1'b0; cpu_addr = 8'h40; cpu_wdata = 8'hC3;
         dbg_req = (k < 12); dbg_we = 1'b0; dbg_addr = 8'h41; dbg_wdata = 8'hC3;
         #5;
         check($sformatf("cont%0d cpu_gnt", k), 32'(cpu_gnt), 32'((k < 12) && exp_cpu[k]));
         check($sformatf("cont%0d dbg_gnt", k), 32'(dbg_gnt), 32'((k < 12) && !exp_cpu[k]));
         if (k >= 2) begin
            check($sformatf("cont%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'(exp_cpu[k-2]));
            check($sformatf("cont%0d dbg_rvalid", k), 32'(dbg_rvalid), 32'(!exp_cpu[k-2]));
            check($sformatf("cont%0d cpu_rdata", k), 32'(cpu_rdata), exp_cpu[k-2] ? 32'h1A : 32'h0);
            check($sformatf("cont%0d dbg_rdata", k), 32'(dbg_rdata), exp_cpu[k-2] ? 32'h0 : 32'h1B);
         end
      end

      // Reset one cycle after a CPU read grant: that read never returns.
      @(posedge clk);
      #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
      dbg_req = 1'b0;
      #5;
      check("rstmid cpu_gnt", 32'(cpu_gnt), 1);
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      reset   = 1'b0;
      for (int j = 0; j < 4; j++) begin
         #5;
         check($sformatf("rstmid%0d cpu_rvalid", j), 32'(cpu_rvalid), 0);
         check($sformatf("rstmid%0d cpu_rdata", j),  32'(cpu_rdata),  0);
         check($sformatf("rstmid%0d dbg_rvalid", j), 32'(dbg_rvalid), 0);
         check($sformatf("rstmid%0d owner", j),      32'(owner),      0);
         @(posedge clk);
         #1;
         reset = 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the machine's single-port 8-bit RAM between the CPU and a debug/loader port. It sits between `cpu` and `ram` inside `machine`: it accepts read/write requests from both masters, grants one per cycle, drives the RAM address/data/write-enable, and returns read data to the granted master. It also enforces a burst limit so neither master starves the other.

## Interface
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 8: RAM data width.
- `MAX_BURST`, 4: maximum consecutive grants to one master while the other is requesting; legal range 1..15.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `cpu_req`, `dbg_req`  in  1  request valid; held with command stable until the matching `*_gnt`.
- `cpu_we`, `dbg_we`  in  1  1 = write, 0 = read.
- `cpu_addr`, `dbg_addr`  in  ADDR_W  target address.
- `cpu_wdata`, `dbg_wdata`  in  DATA_W  write data.
- `cpu_gnt`, `dbg_gnt`  out  1  combinational accept; the request is consumed this cycle.
- `cpu_rvalid`, `dbg_rvalid`  out  1  one-cycle pulse; read data valid.
- `cpu_rdata`, `dbg_rdata`  out  DATA_W  read data; 0 when `*_rvalid` is low.
- `ram_addr`  out  ADDR_W  registered RAM address.
- `ram_wdata`  out  DATA_W  registered RAM write data.
- `ram_we`  out  1  registered write strobe, one cycle per granted write.
- `ram_rdata`  in  DATA_W  RAM read data, valid one cycle after `ram_addr`.
- `owner`  out  2  registered owner of the last issued access: 0 = none, 1 = CPU, 2 = DBG.

## Operation
- States: `IDLE`, `OWN_CPU`, `OWN_DBG`. The state records the master granted last cycle.
- Arbitration happens each cycle over the current `cpu_req`/`dbg_req`:
  - If exactly one master is requesting, it wins.
  - If both are requesting, the default winner is the CPU.
  - Burst override: if the current owner's burst count equals `MAX_BURST`, the other master wins instead.
- Burst counter:
  - Increments on each consecutive grant to the same master.
  - Reloads to 1 when ownership changes.
  - Clears to 0 in `IDLE`.
  - Saturates; it never wraps.
- A cycle with no request moves the FSM to `IDLE`, sets `owner` to 0, and deasserts `ram_we`. `ram_addr` and `ram_wdata` hold their previous values.
- A granted write pulses `ram_we` for exactly one cycle and produces no `rvalid`.
- A granted read produces exactly one `rvalid` pulse to the master that issued it, even if ownership has since changed. A 2-entry tag shift register tracks which master each read belongs to.
- Reset, including mid-operation:
  - All outputs go to 0 and the FSM goes to `IDLE`.
  - In-flight read tags are discarded, so no `rvalid` is issued for reads granted before reset.
  - The first grant after reset release is evaluated on the first rising edge with `reset` = 1.

## Timing
- Cycle N: `req` is high and `gnt` is high in the same cycle (Mealy).
- Cycle N+1: `ram_addr`, `ram_wdata` and `ram_we` are valid.
- Cycle N+2: `ram_rdata` is sampled; `rvalid` and `rdata` are asserted.
- Read latency is 2 cycles from grant; write latency is 1 cycle from grant.
- Throughput: one access per cycle, back-to-back, with no bubble on an ownership switch.
- Read-after-write to the same address on consecutive grants returns the new data, because the RAM write completes at N+1 before the read address is presented at N+2.

## Configuration
- `RAM_ARB_RR_EN` defined: when both masters request, the winner is the master that did not own the previous cycle (round-robin). `MAX_BURST` is ignored.
- `RAM_ARB_RR_EN` undefined: CPU fixed priority, with the `MAX_BURST` override as described above.

## Structure
- Shared package `machine_pkg` holds:
  - `ram_owner_e` enum (`OWN_NONE`=0, `OWN_CPU`=1, `OWN_DBG`=2).
  - `RAM_ADDR_W` and `RAM_DATA_W` constants.
- One sub-module, `arb_burst_cnt`: a saturating counter with `clear`, `load1` and `inc` inputs and a `limit` compare output.
- The FSM, tag pipeline and RAM output registers stay in `ram_arbiter`.

## Test plan
- Reset check: hold `reset` = 0 with both reqs high. Required: all outputs 0. Release `reset`, then CPU read of 0x00 with `ram_rdata` = 0x5A. Required: `cpu_gnt` in cycle 0, `cpu_rvalid` with `cpu_rdata` = 0x5A in cycle 2.
- Write/read: DBG write 0x3C to 0x10. Required: `ram_we` = 1 for one cycle, `ram_addr` = 0x10, `ram_wdata` = 0x3C. Then DBG read 0x10. Required: `dbg_rdata` = 0x3C.
- Contention, fixed priority: both masters request continuously. Required: grant sequence CPU, CPU, CPU, CPU, DBG, CPU×4, DBG, and so on, with `MAX_BURST` = 4.
- Contention, `RAM_ARB_RR_EN`: both masters request continuously. Required: strictly alternating CPU, DBG grants.
- Ownership switch during reads: CPU reads 0x01, then DBG reads 0x02 on the next cycle. Required: `cpu_rvalid` then `dbg_rvalid` on consecutive cycles, each with its own data, and no cross-delivery.
- Reset mid-read: assert `reset` = 0 one cycle after a CPU read grant. Required: no `cpu_rvalid` ever appears for that read, and `owner` = 0.
